rtc_write_sequencer: RTL and testbench
======================================

# rtc_write_sequencer

Drives the parallel multiplexed address/data bus of the external RTC (V3023-style) to commit a keyboard-edited time into the chip. It sits downstream of the keyboard key-detection stage: it consumes that stage's write request and its BCD seconds/minutes/hours values. It performs three register writes followed by one commit-command write, with programmable strobe timing. Values are range-checked before any bus activity.

## Interface
Parameters:
- T_SU, 2, cycles cs_n low with wr_n high before strobe (setup)
- T_WR, 4, cycles wr_n low (strobe width)
- T_HD, 2, cycles wr_n high with cs_n still low after strobe (hold)
- T_GAP, 2, cycles cs_n high and bus released between phases
- ADDR_SEG, 8'h21, RTC seconds register address
- ADDR_MIN, 8'h22, RTC minutes register address
- ADDR_HOR, 8'h23, RTC hours register address
- ADDR_COMMIT, 8'hF1, RTC transfer-command address (data byte 8'h00)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately
- start  in  1  single-cycle write request
- seg_bcd  in  8  seconds, packed BCD
- min_bcd  in  8  minutes, packed BCD
- hor_bcd  in  8  hours, packed BCD, 24 h format
- cs_n  out  1  RTC chip select, active-low
- ad_sel  out  1  0 = address phase, 1 = data phase
- wr_n  out  1  write strobe, active-low
- rd_n  out  1  read strobe, held at 1 (write-only block)
- ad_out  out  8  bus value to drive
- ad_oe  out  1  tri-state enable for ad_out (top level instantiates the pad)
- busy  out  1  transaction sequence in progress
- done  out  1  one-cycle pulse when the commit write completes
- error  out  1  one-cycle pulse when a request is rejected

## Operation
- Reset values: cs_n=1, ad_sel=1, wr_n=1, rd_n=1, ad_out=8'h00, ad_oe=0, busy=0, done=0, error=0, FSM in IDLE.
- start is acted on only in IDLE. While busy, start is ignored and not queued.
- On an accepted start, the three inputs are latched in the same edge. Validation uses the raw inputs:
  - each nibble must be ≤ 9
  - seg ≤ 8'h59, min ≤ 8'h59, hor ≤ 8'h23
- If validation fails: error pulses the next cycle, no bus activity, FSM stays in IDLE.
- Transaction order: (ADDR_SEG, seg), (ADDR_MIN, min), (ADDR_HOR, hor), (ADDR_COMMIT, 8'h00).
- Each transaction is an address phase (ad_sel=0, ad_out=address) followed by a data phase (ad_sel=1, ad_out=data).
- Phase sub-states, each counted by a down-counter reloaded on entry:
  - SETUP (T_SU): cs_n=0, ad_oe=1, wr_n=1
  - STROBE (T_WR): wr_n=0
  - HOLD (T_HD): wr_n=1, cs_n=0, ad_oe=1
  - GAP (T_GAP): cs_n=1, ad_oe=0, ad_out keeps its last value
- ad_sel and ad_out are stable from the first SETUP cycle through the last HOLD cycle of a phase.
- Top FSM: IDLE → RUN (phase index 0..7) → DONE → IDLE. DONE lasts exactly one cycle and asserts done.
- An index counter (3 bits) selects address/data. Bit 0 gives the phase, bits 2:1 give the transaction.
- A parameter value of 0 is illegal. The bench checks that each parameter is ≥ 1; the RTL may assume ≥ 1.

## Timing
- P = T_SU+T_WR+T_HD+T_GAP (default 10). Full sequence = 8·P cycles (default 80).
- start sampled high at edge k with valid data:
  - busy=1 and first SETUP cycle from cycle k+1
  - last GAP cycle at k+8P
  - done=1 and busy=0 at cycle k+8P+1
- With defaults, wr_n falls at k+3, k+13, …, k+73, and each low pulse lasts 4 cycles.
- start at k with invalid data: error=1 at k+1 only; busy never rises.
- start in the DONE cycle is ignored; start at DONE+1 (IDLE) is accepted.
- An input change during busy has no effect, because values were latched at start.
- Reset asserted mid-sequence: outputs go to reset values asynchronously with no partial-strobe completion. After release the FSM is in IDLE and done does not pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package rtc_pkg:
  - RTC address constants (21/22/23/F1)
  - phase enum {SETUP, STROBE, HOLD, GAP}
  - top-state enum {IDLE, RUN, DONE}
  - function bcd_valid(value, max)
- Sub-module rtc_bus_phase: runs one phase given address-or-data, value and go. It returns phase_done and drives cs_n/wr_n/ad_oe/ad_sel/ad_out. The sequencer instantiates it once and steps the index.

## Test plan
- Reset, then start with seg=8'h45, min=8'h30, hor=8'h12, defaults:
  - 8 phases with ad_out sequence 21,45,22,30,23,12,F1,00
  - ad_sel alternates 0/1
  - done at k+81
- Strobe check: each wr_n low pulse lasts exactly 4 cycles, with cs_n low ≥2 cycles before and after. ad_out is stable while cs_n=0.
- Invalid input: hor=8'h24, then separately seg=8'h5A → error pulse at k+1, cs_n stays 1, busy stays 0.
- start asserted again at k+20 and at DONE cycle → ignored; exactly one done pulse; a new start at DONE+1 begins a fresh sequence.
- Reset low at k+35 (mid data-phase strobe) → cs_n=wr_n=1 and ad_oe=0 immediately. After release there is no bus activity until the next start.
- T_SU=1, T_WR=1, T_HD=1, T_GAP=1 → sequence length 32 cycles, done at k+33.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants, state encodings and BCD range checking for the
// RTC write sequencer slice.
//   RTC_ADDR_*  : register/command addresses of the V3023-style RTC
//   phase_e     : bus phase sub-states (SETUP, STROBE, HOLD, GAP)
//   top_state_e : sequencer states (IDLE, RUN, DONE)
//   bcd_valid() : packed-BCD digit check plus upper bound
package rtc_pkg;

  localparam logic [7:0] RTC_ADDR_SEG    = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN    = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOR    = 8'h23;
  localparam logic [7:0] RTC_ADDR_COMMIT = 8'hF1;
  localparam logic [7:0] RTC_COMMIT_DATA = 8'h00;

  typedef enum logic [1:0] {
    PH_SETUP  = 2'd0,
    PH_STROBE = 2'd1,
    PH_HOLD   = 2'd2,
    PH_GAP    = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } top_state_e;

  // Both nibbles must be decimal digits; for packed BCD with legal digits a
  // plain binary compare against the BCD maximum orders values correctly.
  function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
    return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/rtc_write_sequencer_bus_phase.sv
// rtc_bus_phase: runs one bus phase (SETUP -> STROBE -> HOLD -> GAP) for a
// single address or data byte.
//   go         : start a phase this edge with sel/value (takes priority, so
//                phases chain back-to-back from the last GAP cycle)
//   sel/value  : ad_sel level and byte to drive for this phase
//   phase_done : high during the last GAP cycle of the running phase
//   cs_n/wr_n/ad_oe/ad_sel/ad_out : registered bus outputs
module rtc_bus_phase
  import rtc_pkg::*;
#(
  parameter int T_SU  = 2,
  parameter int T_WR  = 4,
  parameter int T_HD  = 2,
  parameter int T_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       sel,
  input  logic [7:0] value,
  output logic       phase_done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       ad_oe,
  output logic       ad_sel,
  output logic [7:0] ad_out
);

  localparam logic [7:0] CNT_SU  = 8'(T_SU);
  localparam logic [7:0] CNT_WR  = 8'(T_WR);
  localparam logic [7:0] CNT_HD  = 8'(T_HD);
  localparam logic [7:0] CNT_GAP = 8'(T_GAP);

  logic       active_q, active_d;
  phase_e     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       ad_oe_q, ad_oe_d;
  logic       ad_sel_q, ad_sel_d;
  logic [7:0] ad_out_q, ad_out_d;

  assign phase_done = active_q && (phase_q == PH_GAP) && (cnt_q == 8'd1);

  // Sub-state sequencing with a reloading down-counter; outputs are decoded
  // from the next state so the registered pins line up with the state.
  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    ad_sel_d = ad_sel_q;
    ad_out_d = ad_out_q;
    if (go) begin
      active_d = 1'b1;
      phase_d  = PH_SETUP;
      cnt_d    = CNT_SU;
      ad_sel_d = sel;
      ad_out_d = value;
    end else if (active_q) begin
      if (cnt_q > 8'd1) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        case (phase_q)
          PH_SETUP:  begin phase_d = PH_STROBE; cnt_d = CNT_WR;  end
          PH_STROBE: begin phase_d = PH_HOLD;   cnt_d = CNT_HD;  end
          PH_HOLD:   begin phase_d = PH_GAP;    cnt_d = CNT_GAP; end
          PH_GAP:    begin active_d = 1'b0; end
          default:   begin active_d = 1'b0; end
        endcase
      end
    end else begin
      cnt_d = cnt_q;
    end
    cs_n_d  = !(active_d && (phase_d != PH_GAP));
    wr_n_d  = !(active_d && (phase_d == PH_STROBE));
    ad_oe_d = !cs_n_d;
  end

  // State and output registers; async reset drops the strobe immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      phase_q  <= PH_SETUP;
      cnt_q    <= 8'd0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_oe_q  <= 1'b0;
      ad_sel_q <= 1'b1;
      ad_out_q <= 8'h00;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      ad_oe_q  <= ad_oe_d;
      ad_sel_q <= ad_sel_d;
      ad_out_q <= ad_out_d;
    end
  end

  assign cs_n   = cs_n_q;
  assign wr_n   = wr_n_q;
  assign ad_oe  = ad_oe_q;
  assign ad_sel = ad_sel_q;
  assign ad_out = ad_out_q;

endmodule

// File: rtl/rtc_write_sequencer.sv
// rtc_write_sequencer: commits a BCD time into a V3023-style RTC as three
// register writes (seconds, minutes, hours) plus a transfer command, each an
// address phase followed by a data phase on the multiplexed bus.
//   start, seg_bcd/min_bcd/hor_bcd : write request and values (latched on accept)
//   cs_n, ad_sel, wr_n, rd_n, ad_out, ad_oe : RTC bus (registered)
//   busy : sequence running; done : commit finished; error : request rejected
module rtc_write_sequencer
  import rtc_pkg::*;
#(
  parameter int         T_SU        = 2,
  parameter int         T_WR        = 4,
  parameter int         T_HD        = 2,
  parameter int         T_GAP       = 2,
  parameter logic [7:0] ADDR_SEG    = RTC_ADDR_SEG,
  parameter logic [7:0] ADDR_MIN    = RTC_ADDR_MIN,
  parameter logic [7:0] ADDR_HOR    = RTC_ADDR_HOR,
  parameter logic [7:0] ADDR_COMMIT = RTC_ADDR_COMMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] seg_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] hor_bcd,
  output logic       cs_n,
  output logic       ad_sel,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  top_state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] seg_q, seg_d, min_q, min_d, hor_q, hor_d;
  logic       busy_q, busy_d, done_q, done_d, error_q, error_d, rd_n_q;
  logic       valid_s, go_s, phase_done_s;
  logic [7:0] phase_val_s;

  assign valid_s = bcd_valid(seg_bcd, 8'h59) && bcd_valid(min_bcd, 8'h59) &&
                   bcd_valid(hor_bcd, 8'h23);

  // Sequencer: accept/reject in IDLE, step the phase index on each phase end.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    min_d   = min_q;
    hor_d   = hor_q;
    go_s    = 1'b0;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && valid_s) begin
          state_d = ST_RUN;
          idx_d   = 3'd0;
          seg_d   = seg_bcd;
          min_d   = min_bcd;
          hor_d   = hor_bcd;
          go_s    = 1'b1;
        end else begin
          error_d = start;
        end
      end
      ST_RUN: begin
        if (phase_done_s) begin
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            go_s  = 1'b1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // Byte for the phase being launched: bits 2:1 pick the transaction, bit 0
  // picks address (0) or data (1). Index 0 only needs a constant address, so
  // the latched values are always settled by the time they are selected.
  always_comb begin
    case (idx_d)
      3'd0:    phase_val_s = ADDR_SEG;
      3'd1:    phase_val_s = seg_q;
      3'd2:    phase_val_s = ADDR_MIN;
      3'd3:    phase_val_s = min_q;
      3'd4:    phase_val_s = ADDR_HOR;
      3'd5:    phase_val_s = hor_q;
      3'd6:    phase_val_s = ADDR_COMMIT;
      3'd7:    phase_val_s = RTC_COMMIT_DATA;
      default: phase_val_s = 8'h00;
    endcase
  end

  // Sequencer state and status output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      seg_q   <= 8'h00;
      min_q   <= 8'h00;
      hor_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rd_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      min_q   <= min_d;
      hor_q   <= hor_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      rd_n_q  <= 1'b1;
    end
  end

  rtc_bus_phase #(
    .T_SU (T_SU),
    .T_WR (T_WR),
    .T_HD (T_HD),
    .T_GAP(T_GAP)
  ) u_phase (
    .clk       (clk),
    .reset     (reset),
    .go        (go_s),
    .sel       (idx_d[0]),
    .value     (phase_val_s),
    .phase_done(phase_done_s),
    .cs_n      (cs_n),
    .wr_n      (wr_n),
    .ad_oe     (ad_oe),
    .ad_sel    (ad_sel),
    .ad_out    (ad_out)
  );

  assign rd_n  = rd_n_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: instance A uses default timing, instance B
// uses 1-cycle timing. A cycle-level reference model derives the expected bus
// waveform from the start cycle and the timing parameters.
module tb_rtc_write_sequencer;

  localparam int SU_A = 2, WR_A = 4, HD_A = 2, GP_A = 2;
  localparam int SU_B = 1, WR_B = 1, HD_B = 1, GP_B = 1;

  logic clk = 1'b0;
  logic reset, start_a, start_b;
  logic [7:0] seg, min, hor;
  logic cs_n_a, ad_sel_a, wr_n_a, rd_n_a, ad_oe_a, busy_a, done_a, error_a;
  logic cs_n_b, ad_sel_b, wr_n_b, rd_n_b, ad_oe_b, busy_b, done_b, error_b;
  logic [7:0] ad_out_a, ad_out_b;

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = A, 1 = B
  int         su[2], wr[2], hd[2], per[2];
  bit         act[2];
  int         t[2];
  logic [7:0] dat[2][3];
  logic       last_sel[2];
  logic [7:0] last_out[2];
  logic       err_exp[2];
  logic [7:0] addrs[4];

  always #5 clk = ~clk;

  rtc_write_sequencer #(.T_SU(SU_A), .T_WR(WR_A), .T_HD(HD_A), .T_GAP(GP_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .seg_bcd(seg), .min_bcd(min), .hor_bcd(hor),
    .cs_n(cs_n_a), .ad_sel(ad_sel_a), .wr_n(wr_n_a), .rd_n(rd_n_a), .ad_out(ad_out_a),
    .ad_oe(ad_oe_a), .busy(busy_a), .done(done_a), .error(error_a));

  rtc_write_sequencer #(.T_SU(SU_B), .T_WR(WR_B), .T_HD(HD_B), .T_GAP(GP_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .seg_bcd(seg), .min_bcd(min), .hor_bcd(hor),
    .cs_n(cs_n_b), .ad_sel(ad_sel_b), .wr_n(wr_n_b), .rd_n(rd_n_b), .ad_out(ad_out_b),
    .ad_oe(ad_oe_b), .busy(busy_b), .done(done_b), .error(error_b));

  function automatic bit is_valid(input logic [7:0] v, input int maxdec);
    int tens, units;
    tens  = int'(v) / 16;
    units = int'(v) % 16;
    return (tens <= 9) && (units <= 9) && (tens * 10 + units <= maxdec);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; t[d] = 0; last_sel[d] = 1'b1; last_out[d] = 8'h00; err_exp[d] = 1'b0;
    end
  endtask

  task automatic check_dut(input int d, input logic cs, input logic w, input logic r,
                           input logic oe, input logic sl, input logic [7:0] o,
                           input logic bz, input logic dn, input logic er);
    string nm;
    logic e_cs, e_wr, e_oe, e_bz, e_dn, e_sel;
    logic [7:0] e_out;
    int p, q;
    nm = (d == 0) ? "A" : "B";
    e_cs = 1'b1; e_wr = 1'b1; e_oe = 1'b0; e_bz = 1'b0; e_dn = 1'b0;
    e_sel = last_sel[d]; e_out = last_out[d];
    if (act[d] && t[d] >= 1 && t[d] <= 8 * per[d]) begin
      p = (t[d] - 1) / per[d];
      q = (t[d] - 1) % per[d];
      e_sel = p[0];
      e_out = (p % 2 == 0) ? addrs[p / 2] : ((p / 2 == 3) ? 8'h00 : dat[d][p / 2]);
      e_cs  = !(q < su[d] + wr[d] + hd[d]);
      e_wr  = !(q >= su[d] && q < su[d] + wr[d]);
      e_oe  = !e_cs;
      e_bz  = 1'b1;
      last_sel[d] = e_sel;
      last_out[d] = e_out;
    end else if (act[d] && t[d] == 8 * per[d] + 1) begin
      e_dn = 1'b1;
    end
    chk({nm, " cs_n"}, 32'(cs), 32'(e_cs));
    chk({nm, " wr_n"}, 32'(w), 32'(e_wr));
    chk({nm, " rd_n"}, 32'(r), 32'(1'b1));
    chk({nm, " ad_oe"}, 32'(oe), 32'(e_oe));
    chk({nm, " ad_sel"}, 32'(sl), 32'(e_sel));
    chk({nm, " ad_out"}, 32'(o), 32'(e_out));
    chk({nm, " busy"}, 32'(bz), 32'(e_bz));
    chk({nm, " done"}, 32'(dn), 32'(e_dn));
    chk({nm, " error"}, 32'(er), 32'(err_exp[d]));
  endtask

  task automatic check_both();
    check_dut(0, cs_n_a, wr_n_a, rd_n_a, ad_oe_a, ad_sel_a, ad_out_a, busy_a, done_a, error_a);
    check_dut(1, cs_n_b, wr_n_b, rd_n_b, ad_oe_b, ad_sel_b, ad_out_b, busy_b, done_b, error_b);
  endtask

  // one clock: present starts, let the model decide acceptance, then compare
  task automatic tick(input logic sa, input logic sb);
    logic s[2];
    logic enx[2];
    s[0] = sa; s[1] = sb;
    start_a = sa; start_b = sb;
    for (int d = 0; d < 2; d++) begin
      enx[d] = 1'b0;
      if (s[d] && !act[d]) begin
        if (is_valid(seg, 59) && is_valid(min, 59) && is_valid(hor, 23)) begin
          act[d] = 1'b1; t[d] = 0;
          dat[d][0] = seg; dat[d][1] = min; dat[d][2] = hor;
        end else begin
          enx[d] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    start_a = 1'b0; start_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (act[d]) begin
        t[d]++;
        if (t[d] > 8 * per[d] + 1) act[d] = 1'b0;
      end
      err_exp[d] = enx[d];
    end
    check_both();
  endtask

  task automatic rand_any();
    seg = 8'($urandom); min = 8'($urandom); hor = 8'($urandom);
  endtask

  task automatic rand_valid();
    int ht;
    seg = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    min = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
    ht  = $urandom_range(0, 2);
    hor = {4'(ht), 4'((ht == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9))};
  endtask

  // run with scrambled inputs until both models are idle, bounded
  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((act[0] || act[1]) && n < budget) begin
      rand_any();
      tick(1'b0, 1'b0);
      n++;
    end
    if (act[0] || act[1]) chk("run_budget", 32'd1, 32'd0);
  endtask

  initial begin
    su[0] = SU_A; wr[0] = WR_A; hd[0] = HD_A; per[0] = SU_A + WR_A + HD_A + GP_A;
    su[1] = SU_B; wr[1] = WR_B; hd[1] = HD_B; per[1] = SU_B + WR_B + HD_B + GP_B;
    if (SU_A < 1 || WR_A < 1 || HD_A < 1 || GP_A < 1 ||
        SU_B < 1 || WR_B < 1 || HD_B < 1 || GP_B < 1) begin
      $display("FAIL param_range: every timing parameter must be at least 1");
      $fatal(1);
    end
    addrs[0] = 8'h21; addrs[1] = 8'h22; addrs[2] = 8'h23; addrs[3] = 8'hF1;
    model_reset();
    start_a = 1'b0; start_b = 1'b0; seg = 8'h00; min = 8'h00; hor = 8'h00;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_both();
    @(posedge clk); #1;
    check_both();
    reset = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // directed sequence; A re-requested at k+20 and at its DONE cycle, B at DONE
    seg = 8'h45; min = 8'h30; hor = 8'h12;
    tick(1'b1, 1'b1);
    for (int c = 0; c < 90; c++) begin
      rand_valid();
      tick((act[0] && t[0] == 20) || (act[0] && t[0] == 8 * per[0] + 1),
           act[1] && t[1] == 8 * per[1] + 1);
    end

    // back-to-back: new start in the cycle right after DONE
    rand_valid();
    tick(1'b1, 1'b0);
    for (int c = 0; c < 200 && !(act[0] && t[0] == 8 * per[0] + 1); c++) begin
      rand_any();
      tick(1'b0, 1'b0);
    end
    chk("A reached done", 32'(act[0] && t[0] == 8 * per[0] + 1), 32'd1);
    tick(1'b0, 1'b0);
    rand_valid();
    tick(1'b1, 1'b1);
    // reset in the middle of the minutes data strobe
    for (int c = 0; c < 100 && t[0] < 35; c++) begin
      rand_any();
      tick(1'b0, 1'b0);
    end
    #1 reset = 1'b0;
    #1 model_reset();
    check_both();
    tick(1'b0, 1'b0);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) tick(1'b0, 1'b0);

    // rejected requests
    seg = 8'h30; min = 8'h15; hor = 8'h24;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    seg = 8'h5A; min = 8'h15; hor = 8'h10;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    seg = 8'h60; min = 8'h00; hor = 8'h00;
    tick(1'b1, 1'b0);
    seg = 8'h00; min = 8'h0F; hor = 8'h00;
    tick(1'b0, 1'b1);
    seg = 8'h59; min = 8'h59; hor = 8'h23;
    tick(1'b1, 1'b1);
    run_idle(200);

    // randomized requests, some out of range
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 3) == 0) rand_any(); else rand_valid();
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < int'($urandom_range(0, 40)); c++) begin
        rand_valid();
        tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
      end
      run_idle(400);
      tick(1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
